// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control FSM with memory handshake, timeout and illegal-opcode traps
module multicycle_control #(
  parameter int ALUOP_W     = 7,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic [1:0]         mem_read,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               trap
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  logic [3:0]       state_q, state_d;
  logic [TMR_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             trap_q, trap_d;
  logic             waiting, timeout;

  logic               pc_write_s, pc_write_cond_s, ir_write_s, i_or_d_s;
  logic               reg_dst_s, mem_to_reg_s, mem_write_s, alu_src_a_s, reg_write_s;
  logic [1:0]         mem_read_s, alu_src_b_s, pc_source_s;
  logic [ALUOP_W-1:0] alu_op_s;

  always_comb begin
    waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout = waiting && !mem_ready && (wait_cnt_q == TMR_W'(MEM_TIMEOUT));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:            state_d = S_EXEC;
          OP_LB, OP_LH, OP_LW: state_d = S_MEMADR;
          OP_SW:               state_d = S_MEMADR;
          OP_BEQ:              state_d = S_BRANCH;
          OP_J:                state_d = S_JUMP;
          OP_ADDI:             state_d = S_ADDIEX;
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  // Counting only while stalled in the same wait state gives clear-on-entry and clear-on-ready for free.
  always_comb begin
    wait_cnt_d = '0;
    if (waiting && !mem_ready && (state_d == state_q)) wait_cnt_d = wait_cnt_q + TMR_W'(1);
    trap_d = trap_q || (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
    end
  end

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    ir_write_s      = 1'b0;
    i_or_d_s        = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    mem_write_s     = 1'b0;
    mem_read_s      = 2'b00;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = ALU_ADD;
    reg_write_s     = 1'b0;
    pc_source_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 2'b11;
        alu_src_b_s = 2'b01;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      S_DECODE: alu_src_b_s = 2'b11;
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMRD: begin
        i_or_d_s = 1'b1;
        case (opcode)
          OP_LB:   mem_read_s = 2'b01;
          OP_LH:   mem_read_s = 2'b10;
          default: mem_read_s = 2'b11;
        endcase
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      S_MEMWR: begin
        i_or_d_s    = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = ALU_SUB;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
      end
      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
      end
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      default: ;
    endcase
  end

  // Reset forces every output low combinationally so an aborted instruction cannot strobe anything.
  always_comb begin
    pc_write      = rst_n & pc_write_s;
    pc_write_cond = rst_n & pc_write_cond_s;
    ir_write      = rst_n & ir_write_s;
    i_or_d        = rst_n & i_or_d_s;
    reg_dst       = rst_n & reg_dst_s;
    mem_to_reg    = rst_n & mem_to_reg_s;
    mem_write     = rst_n & mem_write_s;
    mem_read      = rst_n ? mem_read_s  : 2'b00;
    alu_src_a     = rst_n & alu_src_a_s;
    alu_src_b     = rst_n ? alu_src_b_s : 2'b00;
    alu_op        = rst_n ? alu_op_s    : '0;
    reg_write     = rst_n & reg_write_s;
    pc_source     = rst_n ? pc_source_s : 2'b00;
    state         = rst_n ? state_q     : 4'd0;
    trap          = rst_n & trap_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, reg_dst, mem_to_reg, mem_write;
  logic [1:0] mem_read, alu_src_b, pc_source;
  logic       alu_src_a, reg_write, trap;
  logic [6:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.ALUOP_W(7), .MEM_TIMEOUT(15), .TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .mem_read(mem_read), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .pc_source(pc_source), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  logic [26:0] outs;
  assign outs = {pc_write, pc_write_cond, ir_write, i_or_d, reg_dst, mem_to_reg, mem_write,
                 mem_read, alu_src_a, alu_src_b, alu_op, reg_write, pc_source, state, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
    #2;
    check("reset_outs_zero", 32'(outs), 32'h0);
    tick();
    check("reset_outs_after_edge", 32'(outs), 32'h0);
    rst_n = 1'b1; #1;

    // R-type
    check("r_fetch_state", 32'(state), 0);
    check("r_fetch_strobes", {29'b0, ir_write, pc_write, mem_read == 2'b11}, 32'h7);
    check("r_fetch_alusrcb", 32'(alu_src_b), 1);
    tick(); check("r_decode_state", 32'(state), 1);
    check("r_decode_alusrcb", 32'(alu_src_b), 3);
    tick(); check("r_exec_state", 32'(state), 6);
    check("r_exec_aluop", 32'(alu_op), 2);
    check("r_exec_regwrite", 32'(reg_write), 0);
    tick(); check("r_rwb_state", 32'(state), 7);
    check("r_rwb_write", {30'b0, reg_write, reg_dst}, 32'h3);
    tick(); check("r_back_fetch", 32'(state), 0);

    // lw with 3 wait cycles in MEMRD
    opcode = 6'b100011; n = 0;
    tick(); n++; tick(); n++;
    check("lw_memadr_state", 32'(state), 2);
    check("lw_memadr_src", {29'b0, alu_src_a, alu_src_b}, 32'h6);
    tick(); n++;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ready = 1'b1; #1; end
      check("lw_memrd_state", 32'(state), 3);
      check("lw_memrd_rd", {29'b0, mem_read, i_or_d}, 32'h7);
      tick(); n++;
    end
    check("lw_memwb_state", 32'(state), 4);
    check("lw_memwb_write", {30'b0, reg_write, mem_to_reg}, 32'h3);
    tick(); n++;
    check("lw_total_cycles", 32'(n), 8);
    check("lw_back_fetch", 32'(state), 0);

    // lb drives byte width
    opcode = 6'b100000;
    tick(); tick(); tick();
    check("lb_memrd_width", 32'(mem_read), 1);
    tick(); tick();

    // sw
    opcode = 6'b101011; n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(mem_write);
      if (i == 3) check("sw_memwr_state", 32'(state), 5);
      tick();
    end
    check("sw_one_write", 32'(n), 1);
    check("sw_back_fetch", 32'(state), 0);

    // beq
    opcode = 6'b000100;
    tick(); tick();
    check("beq_state", 32'(state), 8);
    check("beq_ctrl", {27'b0, pc_write_cond, alu_op[2:0], pc_source[0]}, {27'b0, 1'b1, 3'd1, 1'b1});
    check("beq_pcsrc", 32'(pc_source), 1);
    tick(); check("beq_back_fetch", 32'(state), 0);

    // j
    opcode = 6'b000010;
    tick(); tick();
    check("j_state", 32'(state), 9);
    check("j_ctrl", {29'b0, pc_write, pc_source}, 32'h6);
    tick(); check("j_back_fetch", 32'(state), 0);

    // illegal opcode
    opcode = 6'b111111;
    tick(); check("ill_decode", 32'(state), 1);
    tick(); check("ill_trap_state", 32'(state), 12);
    check("ill_trap_flag", 32'(trap), 1);
    tick(); tick();
    check("ill_trap_sticky", 32'(outs), {23'b0, 4'd12, 1'b1} >> 0);
    do_reset();
    check("ill_reset_state", 32'(state), 0);
    check("ill_reset_trap", 32'(trap), 0);

    // FETCH timeout
    opcode = 6'b000000; mem_ready = 1'b0; #1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += int'(ir_write);
      if (state != 4'd0) n += 100;
      tick();
    end
    check("to_no_irwrite", 32'(n), 0);
    check("to_trap_state", 32'(state), 12);
    check("to_trap_flag", 32'(trap), 1);

    // ready arrives on the last allowed cycle
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_edge_state", 32'(state), 0);
    mem_ready = 1'b1; #1;
    check("to_edge_irwrite", 32'(ir_write), 1);
    tick();
    check("to_edge_decode", 32'(state), 1);
    check("to_edge_notrap", 32'(trap), 0);

    // reset during MEMWR
    opcode = 6'b101011;
    tick(); mem_ready = 1'b0; tick(); tick();
    check("rst_memwr_state", 32'(state), 5);
    check("rst_memwr_write", 32'(mem_write), 1);
    rst_n = 1'b0; #1;
    check("rst_memwr_outs", 32'(outs), 0);
    tick();
    rst_n = 1'b1; opcode = 6'b000000; #1;
    check("rst_memwr_fetch", 32'(state), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      n += int'(mem_write);
      tick();
    end
    check("rst_memwr_nowrite", 32'(n), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
